// File: rtl/dnn_pkg.sv
// Shared types and helpers for the DNN output stages: the argmax FSM state,
// the result-entry layout and a width helper that never returns zero.
package dnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PUSH
  } argmax_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int argmax_entry_width(input int cw, input int bit_size);
    return cw + bit_size + 1;
  endfunction

  // Entry layout at the default DNN configuration; parameterised users pack
  // the same field order with argmax_entry_width.
  localparam int ARGMAX_BIT_SIZE   = 32;
  localparam int ARGMAX_NUM_CLASSES = 2;
  localparam int ARGMAX_CW         = clog2_min1(ARGMAX_NUM_CLASSES);

  typedef struct packed {
    logic [ARGMAX_CW-1:0]       class_idx;
    logic [ARGMAX_BIT_SIZE-1:0] score;
    logic                       last;
  } argmax_entry_t;

endpackage

// File: rtl/dnn_argmax_out_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is on rd_data
// whenever rd_valid is high. Write is accepted when full if a pop happens too.
module sync_fifo_fwft #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_en,
    output logic [Width-1:0] rd_data,
    output logic             rd_valid
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = rd_en && !empty;
    assign wr_ready = !full || do_pop;
    assign do_push  = wr_en && wr_ready;
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: asynchronous reset on the pointers only; sequential state always
    // uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; flushing the pointers makes
    // stale words unreachable and keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dnn_argmax_out.sv
// Output classifier: sequential signed argmax over the final dense layer's
// score vector, one element per cycle, results queued for the host.
module dnn_argmax_out
    import dnn_pkg::*;
#(
    parameter int BitSize    = 32,
    parameter int NumClasses = 2,
    parameter int FifoDepth  = 4,
    parameter int CountBits  = 8
) (
    input  logic                               clk,
    input  logic                               res,
    input  logic                               in_valid,
    input  logic [NumClasses-1:0][BitSize-1:0] in_data,
    input  logic                               in_done,
    output logic                               in_ready,
    input  logic                               out_ready,
    output logic                               out_valid,
    output logic [clog2_min1(NumClasses)-1:0]  out_class,
    output logic [BitSize-1:0]                 out_score,
    output logic                               out_last,
    output logic [CountBits-1:0]               out_count
);
    localparam int CW = clog2_min1(NumClasses);
    localparam int EW = argmax_entry_width(CW, BitSize);

    typedef struct packed {
        logic [CW-1:0]      class_idx;
        logic [BitSize-1:0] score;
        logic               last;
    } entry_t;

    argmax_state_t                      state_r;
    argmax_state_t                      state_next;
    logic [NumClasses-1:0][BitSize-1:0] vec_r;
    logic                               last_r;
    logic [CW-1:0]                      best_idx_r;
    logic signed [BitSize-1:0]          best_val_r;
    logic [CW-1:0]                      idx_r;
    logic [CountBits-1:0]               count_r;
    logic                               accept;
    logic                               push_en;
    logic                               fifo_wr_ready;
    entry_t                             wr_entry;
    entry_t                             head;

    always_ff @(posedge clk or posedge res) begin
        if (res) state_r <= IDLE;
        else     state_r <= state_next;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: if (in_valid) state_next = (NumClasses == 1) ? PUSH : SCAN;
            SCAN: if (idx_r == CW'(NumClasses - 1)) state_next = PUSH;
            PUSH: if (fifo_wr_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_r == IDLE);
        push_en  = (state_r == PUSH) && fifo_wr_ready;
        accept   = (state_r == IDLE) && in_valid;
    end

    // Strictly-greater replacement keeps the lowest index on ties.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            vec_r      <= '0;
            last_r     <= 1'b0;
            best_idx_r <= '0;
            best_val_r <= '0;
            idx_r      <= '0;
        end else begin
            case (state_r)
                IDLE: if (accept) begin
                    vec_r      <= in_data;
                    last_r     <= in_done;
                    best_idx_r <= '0;
                    best_val_r <= in_data[0];
                    idx_r      <= CW'(1);
                end
                SCAN: begin
                    if ($signed(vec_r[idx_r]) > best_val_r) begin
                        best_idx_r <= idx_r;
                        best_val_r <= vec_r[idx_r];
                    end
                    idx_r <= idx_r + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res)                           count_r <= '0;
        else if (push_en && count_r != '1) count_r <= count_r + CountBits'(1);
    end

    assign wr_entry = '{class_idx: best_idx_r, score: best_val_r, last: last_r};

    sync_fifo_fwft #(
        .Width (EW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk      (clk),
        .res      (res),
        .wr_en    (push_en),
        .wr_data  (wr_entry),
        .wr_ready (fifo_wr_ready),
        .rd_en    (out_ready),
        .rd_data  (head),
        .rd_valid (out_valid)
    );

    assign out_class = head.class_idx;
    assign out_score = head.score;
    assign out_last  = head.last;
    assign out_count = count_r;

endmodule
